alu_writeback_stage: RTL
========================

// Module: alu_writeback_stage
// PURPOSE
//  Registered stage directly downstream of the combinational ALU. Captures the ALU result with its
//  opcode, operands and destination register, and derives NZCV flags from them. Buffers results in a
//  small FIFO and delivers them to the register-file write port over a valid/ready handshake.
//  Commits architectural flags in order, on retirement.
// PARAMETERS
//  DATA_W   32  ALU datapath width (res_out width)
//  OP2_W    4   operand2 width (zero-extended immediate)
//  RD_W     4   destination register index width
//  DEPTH    2   buffer entries; power of 2, >=2
// PORTS
//  clk         in   1        single clock, rising edge
//  rst         in   1        synchronous, active-high reset
//  in_valid    in   1        upstream holds a valid ALU result this cycle
//  in_ready    out  1        stage can accept; depends on registered state only
//  in_opcode   in   3        ALU opcode (001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 NOT)
//  in_op1      in   DATA_W   operand1[DATA_W-1:0] as presented to the ALU
//  in_op2      in   OP2_W    operand2 as presented to the ALU
//  in_result   in   DATA_W   ALU res_out
//  in_rd       in   RD_W     destination register
//  wb_valid    out  1        write-back entry at head is valid
//  wb_ready    in   1        register file accepts write this cycle
//  wb_rd       out  RD_W     head destination register
//  wb_data     out  DATA_W   head result
//  flags       out  4        committed {N,Z,C,V}
//  bad_op      out  1        one-cycle pulse: opcode 000/111 was accepted and dropped
// BEHAVIOUR
//  Reset: in_ready=1, wb_valid=0, wb_rd=0, wb_data=0, flags=4'b0000, bad_op=0. Buffer is emptied.
//   Reset wins over any same-cycle handshake; an entry in flight at reset is lost.
//  Accept: in_valid&&in_ready. Valid opcode: push {rd,result,nzcv} into the tail. Opcode 000/111:
//   nothing is pushed; bad_op=1 on the next cycle.
//  Retire: wb_valid&&wb_ready pops the head. flags<=head nzcv in that same edge, strictly in order.
//  Latency: an accept at edge t gives wb_valid=1 after edge t when the buffer was empty (1 cycle).
//  in_ready = !full, registered. A full buffer does not accept in the cycle it also retires.
//  Simultaneous push and pop when non-empty and non-full: count unchanged. Pointers wrap mod DEPTH.
//  Outputs wb_rd/wb_data/wb_valid come from the head register. While wb_valid=1 && !wb_ready,
//   they hold stable.
//  Flag rules (r=in_result, a=in_op1, b=zero-extended in_op2):
//   N=r[DATA_W-1]; Z=(r==0) for all valid opcodes.
//   ADD: C=carry out of a+b at bit DATA_W; V=!a[MSB] && r[MSB].
//   SUB: C=(a>=b) unsigned, i.e. no borrow; V=a[MSB] && !r[MSB].
//   AND/OR/XOR/NOT: C=0, V=0.
//  Flags are computed from the inputs, not recomputed from r, except N and Z.
// STRUCTURE
//  Shared package alu_pkg: opcode localparams (ALU_ADD..ALU_NOT), flag bit indices (FLG_N=3..FLG_V=0),
//   function alu_flags(opcode,a,b,r) returning the 4-bit nzcv.
//  Sub-module wb_fifo: DATA_W+RD_W+4-bit entries, DEPTH deep, rd/wr pointers plus count. Provides
//   full/empty and head outputs. Parent holds the handshake, flag computation and flags register.
// TESTING
//  1. ADD a=32'h7FFF_FFFF, b=1, r=32'h8000_0000, rd=3, wb_ready=1 -> wb_valid next cycle,
//     wb_data=8000_0000. flags=1001 after retire.
//  2. SUB a=5, b=5, r=0 -> flags=0110. SUB a=0, b=1, r=FFFF_FFFF -> flags=1000.
//  3. Back-pressure: wb_ready=0, send 3 ADDs with r=1,2,3 -> third stalls (in_ready=0). Raise wb_ready
//     -> writes 1,2,3 in order. flags change only on each retire.
//  4. Full buffer with wb_ready=1 and in_valid=1 same cycle -> pop only. in_ready=1 next cycle.
//     Then streaming push+pop every cycle for 8 cycles -> 8 writes, no bubbles after the first.
//  5. Opcode 3'b111 accepted -> bad_op pulses 1 cycle, no wb_valid, flags unchanged.
//  6. rst=1 with 2 entries pending and in_valid=1 -> next cycle wb_valid=0, in_ready=1, flags=0000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, flag bit positions and the
// NZCV derivation used by the write-back stage.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_NOT = 3'b110;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    // Widest datapath alu_flags supports; callers zero-extend into this width.
    localparam int ALU_MAX_W = 64;

    // Opcodes 000 and 111 are unassigned and get dropped by the stage.
    function automatic logic alu_op_valid(input logic [2:0] opcode);
        return (opcode != 3'b000) && (opcode != 3'b111);
    endfunction

    // NZCV from the ALU inputs and result. data_w selects the real datapath
    // width inside the ALU_MAX_W containers; masks are used instead of
    // variable bit-selects so the index width never matters.
    function automatic logic [3:0] alu_flags(
        input logic [2:0]           opcode,
        input logic [ALU_MAX_W-1:0] a,
        input logic [ALU_MAX_W-1:0] b,
        input logic [ALU_MAX_W-1:0] r,
        input int                   data_w
    );
        logic [ALU_MAX_W:0] sum;
        logic [ALU_MAX_W:0] msb_mask;
        logic               a_msb;
        logic               r_msb;
        logic [3:0]         nzcv;
        sum      = {1'b0, a} + {1'b0, b};
        msb_mask = {{ALU_MAX_W{1'b0}}, 1'b1} << (data_w - 1);
        a_msb    = |({1'b0, a} & msb_mask);
        r_msb    = |({1'b0, r} & msb_mask);
        nzcv        = '0;
        nzcv[FLG_N] = r_msb;
        nzcv[FLG_Z] = (r == '0);
        case (opcode)
            ALU_ADD: begin
                nzcv[FLG_C] = |(sum & (msb_mask << 1));
                nzcv[FLG_V] = !a_msb && r_msb;
            end
            ALU_SUB: begin
                nzcv[FLG_C] = (a >= b);
                nzcv[FLG_V] = a_msb && !r_msb;
            end
            default: ;
        endcase
        return nzcv;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular buffer holding write-back entries. The head entry is read
// straight from the storage registers so the consumer sees registered data.
module wb_fifo #(
    parameter int ENTRY_W = 40,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output logic [ENTRY_W-1:0] head_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_data = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage is cleared on reset because the head feeds the
            // write-back outputs directly and those must read zero out of reset.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            // NOTE: sequential state uses non-blocking assignments only.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// Registered stage after the ALU: derives NZCV, buffers results and hands
// them to the register-file write port. Flags commit in order on retirement.
// DATA_W must not exceed alu_pkg::ALU_MAX_W.
module alu_writeback_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP2_W  = 4,
    parameter int RD_W   = 4,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_opcode,
    input  logic [DATA_W-1:0] in_op1,
    input  logic [OP2_W-1:0]  in_op2,
    input  logic [DATA_W-1:0] in_result,
    input  logic [RD_W-1:0]   in_rd,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [3:0]        flags,
    output logic              bad_op
);

    localparam int ENTRY_W = RD_W + DATA_W + 4;

    logic               accept;
    logic               op_ok;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [3:0]         in_nzcv;
    logic [3:0]         head_nzcv;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [3:0]         flags_q, flags_d;
    logic               bad_op_q, bad_op_d;

    // in_ready comes only from the registered occupancy, so a full buffer
    // never accepts in the same cycle it retires.
    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;
    assign op_ok    = alu_op_valid(in_opcode);
    assign push     = accept && op_ok;
    assign wb_valid = !fifo_empty;
    assign pop      = wb_valid && wb_ready;

    assign push_entry                     = {in_rd, in_result, in_nzcv};
    assign {wb_rd, wb_data, head_nzcv}    = head_entry;
    assign flags                          = flags_q;
    assign bad_op                         = bad_op_q;

    // Flags are derived from the operands at capture time and travel with the entry.
    always_comb begin
        in_nzcv = alu_flags(in_opcode,
                            ALU_MAX_W'(in_op1),
                            ALU_MAX_W'(in_op2),
                            ALU_MAX_W'(in_result),
                            DATA_W);
    end

    // Commit the head's flags when it retires; flag a dropped illegal opcode.
    always_comb begin
        flags_d  = pop ? head_nzcv : flags_q;
        bad_op_d = accept && !op_ok;
    end

    // Architectural flags and the one-cycle bad_op pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q  <= '0;
            bad_op_q <= 1'b0;
        end else begin
            flags_q  <= flags_d;
            bad_op_q <= bad_op_d;
        end
    end

    wb_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head_entry)
    );

endmodule
